// File: rtl/fab_cfg_pkg.sv
// Shared constants for the fabric configuration frame writer: sync word, header layout, FSM states.
package fab_cfg_pkg;

  localparam logic [31:0] SYNC_WORD      = 32'hFAB0_FAB1;
  localparam int          HDR_DESYNC_BIT = 31;
  localparam int          HDR_COL_MSB    = 30;
  localparam int          HDR_COL_LSB    = 24;
  localparam int          HDR_FRAME_MSB  = 20;
  localparam int          HDR_FRAME_LSB  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEADER = 3'd1,
    DATA   = 3'd2,
    CRC    = 3'd3,
    STROBE = 3'd4
  } state_t;

endpackage

// File: rtl/fab_cfg_strobe_decoder.sv
// Combinational decode of a latched column/frame pair into the flat one-hot FrameStrobe vector.
module fab_cfg_strobe_decoder #(
  parameter int NumberOfCols    = 10,
  parameter int MaxFramesPerCol = 20,
  parameter int COL_W           = 4,
  parameter int FRM_W           = 5
) (
  input  logic                                    en,
  input  logic [COL_W-1:0]                        column,
  input  logic [FRM_W-1:0]                        frame,
  output logic [NumberOfCols*MaxFramesPerCol-1:0] strobe
);

  logic [MaxFramesPerCol-1:0] onehot;

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot = {{(MaxFramesPerCol-1){1'b0}}, 1'b1} << frame;
    end
  end

  for (genvar gi = 0; gi < NumberOfCols; gi++) begin : g_col
    assign strobe[gi*MaxFramesPerCol +: MaxFramesPerCol] =
      (column == COL_W'(gi)) ? onehot : '0;
  end

endmodule

// File: rtl/fab_cfg_frame_writer.sv
// Bitstream word stream -> per-row FrameData and one-hot per-column FrameStrobe.
// Optional per-frame XOR check word enabled by defining CFG_FRAME_CRC_EN.
module fab_cfg_frame_writer
  import fab_cfg_pkg::*;
#(
  parameter int NumberOfRows    = 16,
  parameter int NumberOfCols    = 10,
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20
) (
  input  logic                                    CLK,
  input  logic                                    resetn,
  input  logic [FrameBitsPerRow-1:0]              s_data,
  input  logic                                    s_valid,
  output logic                                    s_ready,
  output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
  output logic [NumberOfCols*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    err
);

  localparam int ROW_W = $clog2(NumberOfRows);
  localparam int COL_W = $clog2(NumberOfCols);
  localparam int FRM_W = $clog2(MaxFramesPerCol);

  state_t             state_reg, state_next;
  logic [ROW_W-1:0]   row_reg;
  logic [COL_W-1:0]   col_reg;
  logic [FRM_W-1:0]   frame_reg;
  logic               done_reg;
  logic               err_reg;
  logic               strobe_en;

  logic               fire;
  logic               hdr_desync;
  logic [6:0]         hdr_col;
  logic [4:0]         hdr_frame;
  logic               hdr_bad;
  logic               last_row;

  assign fire       = s_valid && s_ready;
  assign hdr_desync = s_data[HDR_DESYNC_BIT];
  assign hdr_col    = s_data[HDR_COL_MSB:HDR_COL_LSB];
  assign hdr_frame  = s_data[HDR_FRAME_MSB:HDR_FRAME_LSB];
  assign hdr_bad    = (int'(hdr_col) >= NumberOfCols) || (int'(hdr_frame) >= MaxFramesPerCol);
  assign last_row   = (row_reg == ROW_W'(NumberOfRows-1));

`ifdef CFG_FRAME_CRC_EN
  logic [FrameBitsPerRow-1:0] crc_reg;
  logic                       crc_ok;
  assign crc_ok = (s_data == crc_reg);
`endif

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (fire && (s_data == SYNC_WORD)) state_next = HEADER;
      end
      HEADER: begin
        // Desync wins over range checking: its column/frame fields are don't-care.
        if (fire) state_next = (hdr_desync || hdr_bad) ? IDLE : DATA;
      end
      DATA: begin
`ifdef CFG_FRAME_CRC_EN
        if (fire && last_row) state_next = CRC;
`else
        if (fire && last_row) state_next = STROBE;
`endif
      end
      CRC: begin
`ifdef CFG_FRAME_CRC_EN
        if (fire) state_next = crc_ok ? STROBE : IDLE;
`else
        state_next = IDLE;
`endif
      end
      STROBE:  state_next = HEADER;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_ready   = (state_reg != STROBE);
    busy      = (state_reg != IDLE);
    strobe_en = (state_reg == STROBE);
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      row_reg   <= '0;
      col_reg   <= '0;
      frame_reg <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
`ifdef CFG_FRAME_CRC_EN
      crc_reg   <= '0;
`endif
    end else begin
      done_reg <= 1'b0;
      if (state_reg == HEADER && fire) begin
        if (hdr_desync) begin
          done_reg <= 1'b1;
        end else if (hdr_bad) begin
          err_reg <= 1'b1;
        end else begin
          col_reg   <= hdr_col[COL_W-1:0];
          frame_reg <= hdr_frame[FRM_W-1:0];
          row_reg   <= '0;
`ifdef CFG_FRAME_CRC_EN
          crc_reg   <= s_data;
`endif
        end
      end
      if (state_reg == DATA && fire) begin
        row_reg <= row_reg + 1'b1;
`ifdef CFG_FRAME_CRC_EN
        crc_reg <= crc_reg ^ s_data;
`endif
      end
`ifdef CFG_FRAME_CRC_EN
      if (state_reg == CRC && fire && !crc_ok) err_reg <= 1'b1;
`endif
    end
  end

  // Each row register only loads on its own DATA beat, so rows hold steady through STROBE.
  for (genvar gi = 0; gi < NumberOfRows; gi++) begin : g_row
    logic [FrameBitsPerRow-1:0] row_data_reg;

    always_ff @(posedge CLK) begin
      if (!resetn) begin
        row_data_reg <= '0;
      end else if (state_reg == DATA && fire && row_reg == ROW_W'(gi)) begin
        row_data_reg <= s_data;
      end
    end

    assign FrameData[gi*FrameBitsPerRow +: FrameBitsPerRow] = row_data_reg;
  end

  fab_cfg_strobe_decoder #(
    .NumberOfCols    (NumberOfCols),
    .MaxFramesPerCol (MaxFramesPerCol),
    .COL_W           (COL_W),
    .FRM_W           (FRM_W)
  ) u_strobe_decoder (
    .en     (strobe_en),
    .column (col_reg),
    .frame  (frame_reg),
    .strobe (FrameStrobe)
  );

  assign done = done_reg;
  assign err  = err_reg;

endmodule

// File: tb/tb_fab_cfg_frame_writer.sv
// Self-checking bench for fab_cfg_frame_writer: transaction-level model plus directed frames.
module tb_fab_cfg_frame_writer;

  localparam int ROWS  = 16;
  localparam int COLS  = 10;
  localparam int FBITS = 32;
  localparam int FPC   = 20;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;
`ifdef CFG_FRAME_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic                  CLK = 1'b0;
  logic                  resetn;
  logic [31:0]           s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [ROWS*FBITS-1:0] FrameData;
  logic [COLS*FPC-1:0]   FrameStrobe;
  logic                  busy, done, err;

  fab_cfg_frame_writer #(
    .NumberOfRows(ROWS), .NumberOfCols(COLS), .FrameBitsPerRow(FBITS), .MaxFramesPerCol(FPC)
  ) dut (
    .CLK(CLK), .resetn(resetn), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .FrameData(FrameData), .FrameStrobe(FrameStrobe), .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int P_HUNT = 0, P_HDR = 1, P_ROWS = 2, P_CHK = 3, P_STB = 4;
  int          m_phase = P_HUNT;
  int          m_col = 0, m_frm = 0, m_k = 0;
  logic [31:0] m_x = '0;
  logic [31:0] m_data [ROWS];
  logic        m_done = 1'b0, m_err = 1'b0;

  always @(posedge CLK) begin
    logic acc;
    acc = s_valid && (m_phase != P_STB);
    if (!resetn) begin
      m_phase = P_HUNT; m_done = 1'b0; m_err = 1'b0; m_k = 0;
      for (int r = 0; r < ROWS; r++) m_data[r] = '0;
    end else begin
      m_done = 1'b0;
      case (m_phase)
        P_HUNT: if (acc && s_data == SYNC) m_phase = P_HDR;
        P_HDR: if (acc) begin
          if (s_data[31]) begin
            m_done = 1'b1; m_phase = P_HUNT;
          end else if (int'(s_data[30:24]) >= COLS || int'(s_data[20:16]) >= FPC) begin
            m_err = 1'b1; m_phase = P_HUNT;
          end else begin
            m_col = int'(s_data[30:24]); m_frm = int'(s_data[20:16]);
            m_k = 0; m_x = s_data; m_phase = P_ROWS;
          end
        end
        P_ROWS: if (acc) begin
          m_data[m_k] = s_data; m_x = m_x ^ s_data; m_k++;
          if (m_k == ROWS) m_phase = CRC_ON ? P_CHK : P_STB;
        end
        P_CHK: if (acc) begin
          if (s_data == m_x) m_phase = P_STB;
          else begin m_err = 1'b1; m_phase = P_HUNT; end
        end
        default: m_phase = P_HDR;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 1'b0;
  int hits67 = 0, hits199 = 0, strobe_cycles = 0, done_cycles = 0;

  always @(negedge CLK) begin
    if (cmp_en) begin
      logic [ROWS*FBITS-1:0] exp_fd;
      logic [COLS*FPC-1:0]   exp_fs;
      for (int r = 0; r < ROWS; r++) exp_fd[r*FBITS +: FBITS] = m_data[r];
      exp_fs = '0;
      if (m_phase == P_STB) exp_fs[m_col*FPC + m_frm] = 1'b1;
      chk("frame_data",   512'(FrameData),   512'(exp_fd));
      chk("frame_strobe", 512'(FrameStrobe), 512'(exp_fs));
      chk("s_ready", 512'(s_ready), 512'(m_phase != P_STB));
      chk("busy",    512'(busy),    512'(m_phase != P_HUNT));
      chk("done",    512'(done),    512'(m_done));
      chk("err",     512'(err),     512'(m_err));
      if (FrameStrobe[67])  hits67++;
      if (FrameStrobe[199]) hits199++;
      if (|FrameStrobe)     strobe_cycles++;
      if (done)             done_cycles++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    s_data  = w;
    s_valid = 1'b1;
    while (!s_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 20) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout got=s_ready_low expected=s_ready_high word=%h", w);
    end
    @(negedge CLK);
    s_valid = 1'b0;
  endtask

  function automatic logic [31:0] hdr(input int c, input int f);
    logic [31:0] h;
    h = '0;
    h[30:24] = c[6:0];
    h[20:16] = f[4:0];
    return h;
  endfunction

  task automatic send_frame(input int c, input int f, input logic [31:0] base,
                            input bit stall, input bit sync_row2, input logic [31:0] crc_flip);
    logic [31:0] x, w;
    $display("frame col=%0d frm=%0d base=%h stall=%0d crc_flip=%h", c, f, base, stall, crc_flip);
    x = hdr(c, f);
    send(x);
    for (int r = 0; r < ROWS; r++) begin
      w = (sync_row2 && r == 2) ? SYNC : base + 32'(r);
      if (stall) idle($urandom_range(0, 2));
      send(w);
      x = x ^ w;
    end
    if (CRC_ON) send(x ^ crc_flip);
  endtask

  int s0, d0;

  initial begin
    #200000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (2) @(negedge CLK);
    cmp_en = 1'b1;
    chk("rst_frame_data", 512'(FrameData), 512'(0));
    chk("rst_s_ready", 512'(s_ready), 512'(1));
    chk("rst_err", 512'(err), 512'(0));
    resetn = 1'b1;
    @(negedge CLK);

    // 1: basic frame, column 3 frame 7 -> strobe bit 67
    send(SYNC);
    send_frame(3, 7, 32'h0, 1'b0, 1'b0, 32'h0);
    idle(3);
    chk("t1_row5", 512'(FrameData[5*32 +: 32]), 512'(32'd5));
    chk("t1_row15", 512'(FrameData[15*32 +: 32]), 512'(32'd15));
    chk("t1_hits67", 512'(hits67), 512'(1));
    chk("t1_strobes", 512'(strobe_cycles), 512'(1));

    // 2: column out of range -> err, trailing words ignored
    send(hdr(10, 0));
    idle(2);
    chk("t2_err", 512'(err), 512'(1));
    chk("t2_busy", 512'(busy), 512'(0));
    for (int i = 0; i < 4; i++) send(32'hDEAD_0000 + 32'(i));
    idle(2);
    chk("t2_row3_kept", 512'(FrameData[3*32 +: 32]), 512'(32'd3));
    chk("t2_strobes", 512'(strobe_cycles), 512'(1));

    // 3: stalls, SYNC value as data, boundary column 9 frame 19 -> bit 199
    send(SYNC);
    s0 = strobe_cycles;
    send_frame(9, 19, 32'hA000_0000, 1'b1, 1'b1, 32'h0);
    idle(3);
    chk("t3_row2_sync", 512'(FrameData[2*32 +: 32]), 512'(32'hFAB0_FAB1));
    chk("t3_row15", 512'(FrameData[15*32 +: 32]), 512'(32'hA000_000F));
    chk("t3_hits199", 512'(hits199), 512'(1));
    chk("t3_strobes", 512'(strobe_cycles - s0), 512'(1));

    // 4: back-to-back frames, then desync header
    s0 = strobe_cycles; d0 = done_cycles;
    send_frame(0, 0, 32'h100, 1'b0, 1'b0, 32'h0);
    send_frame(4, 11, 32'h200, 1'b0, 1'b0, 32'h0);
    send(32'h8000_0000);
    idle(3);
    chk("t4_strobes", 512'(strobe_cycles - s0), 512'(2));
    chk("t4_done", 512'(done_cycles - d0), 512'(1));
    chk("t4_busy", 512'(busy), 512'(0));
    chk("t4_row9", 512'(FrameData[9*32 +: 32]), 512'(32'h209));

    // 5: reset after fifth data word aborts the frame
    s0 = strobe_cycles;
    send(SYNC);
    send(hdr(1, 2));
    for (int i = 0; i < 5; i++) send(32'h50 + 32'(i));
    resetn = 1'b0;
    repeat (2) @(negedge CLK);
    chk("t5_frame_data", 512'(FrameData), 512'(0));
    chk("t5_err", 512'(err), 512'(0));
    resetn = 1'b1;
    idle(2);
    chk("t5_no_strobe", 512'(strobe_cycles - s0), 512'(0));
    send(SYNC);
    send_frame(2, 5, 32'h300, 1'b0, 1'b0, 32'h0);
    idle(3);
    chk("t5_row7", 512'(FrameData[7*32 +: 32]), 512'(32'h307));
    chk("t5_strobes", 512'(strobe_cycles - s0), 512'(1));

    // frame index at the limit
    send(hdr(0, 20));
    idle(2);
    chk("frm20_err", 512'(err), 512'(1));
    chk("frm20_busy", 512'(busy), 512'(0));

`ifdef CFG_FRAME_CRC_EN
    // 6: check word good then corrupted
    resetn = 1'b0;
    repeat (2) @(negedge CLK);
    resetn = 1'b1;
    @(negedge CLK);
    s0 = strobe_cycles;
    send(SYNC);
    send_frame(6, 3, 32'h1234_0000, 1'b0, 1'b0, 32'h0);
    idle(3);
    chk("t6_good_strobe", 512'(strobe_cycles - s0), 512'(1));
    chk("t6_good_err", 512'(err), 512'(0));
    send_frame(6, 4, 32'h5678_0000, 1'b0, 1'b0, 32'h0000_0100);
    idle(3);
    chk("t6_bad_strobe", 512'(strobe_cycles - s0), 512'(1));
    chk("t6_bad_err", 512'(err), 512'(1));
    chk("t6_bad_busy", 512'(busy), 512'(0));
`endif

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
